// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - decode-stage hazard controller: bypass enables, load-use stall, bubbles
// Optional stall counter built when HAZ_STALL_CNT_EN is defined.
module hazard_ctrl #(
  parameter int ADDR_SIZE = 5,
  parameter int CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [ADDR_SIZE-1:0] D_ra,
  input  logic [ADDR_SIZE-1:0] D_rb,
  input  logic                 D_use_ra,
  input  logic                 D_use_rb,
  input  logic [ADDR_SIZE-1:0] D_rd,
  input  logic                 D_we,
  input  logic                 D_ld,
  input  logic                 D_valid,
  input  logic                 flush,
  input  logic                 hold,
  output logic [1:0]           EX_D_bp,
  output logic [1:0]           MEM_D_bp,
  output logic [1:0]           WB_D_bp,
  output logic                 stall,
  output logic [CNT_W-1:0]     stall_cnt
);

  // The load flag only matters in EX; MEM carries load data and forwards normally.
  logic                 ex_valid, ex_we, ex_ld;
  logic [ADDR_SIZE-1:0] ex_rd;
  logic                 mem_valid, mem_we;
  logic [ADDR_SIZE-1:0] mem_rd;
  logic                 wb_valid, wb_we;
  logic [ADDR_SIZE-1:0] wb_rd;

  logic ex_a, ex_b, mem_a, mem_b, wb_a, wb_b;
  logic bubble;

  function automatic logic hit(input logic                 v,
                               input logic                 we,
                               input logic [ADDR_SIZE-1:0] rd,
                               input logic [ADDR_SIZE-1:0] src,
                               input logic                 use_src,
                               input logic                 dv);
    return v && we && (rd == src) && (src != '0) && use_src && dv;
  endfunction

  always_comb begin
    ex_a  = hit(ex_valid,  ex_we,  ex_rd,  D_ra, D_use_ra, D_valid);
    ex_b  = hit(ex_valid,  ex_we,  ex_rd,  D_rb, D_use_rb, D_valid);
    mem_a = hit(mem_valid, mem_we, mem_rd, D_ra, D_use_ra, D_valid);
    mem_b = hit(mem_valid, mem_we, mem_rd, D_rb, D_use_rb, D_valid);
    wb_a  = hit(wb_valid,  wb_we,  wb_rd,  D_ra, D_use_ra, D_valid);
    wb_b  = hit(wb_valid,  wb_we,  wb_rd,  D_rb, D_use_rb, D_valid);

    EX_D_bp  = {ex_a, ex_b};
    MEM_D_bp = {mem_a & ~ex_a, mem_b & ~ex_b};
    WB_D_bp  = {wb_a & ~mem_a & ~ex_a, wb_b & ~mem_b & ~ex_b};

    stall  = (ex_a | ex_b) & ex_ld & ~flush;
    bubble = flush | stall;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid  <= 1'b0;
      ex_we     <= 1'b0;
      ex_ld     <= 1'b0;
      ex_rd     <= '0;
      mem_valid <= 1'b0;
      mem_we    <= 1'b0;
      mem_rd    <= '0;
      wb_valid  <= 1'b0;
      wb_we     <= 1'b0;
      wb_rd     <= '0;
    end else if (!hold) begin
      wb_valid  <= mem_valid;
      wb_we     <= mem_we;
      wb_rd     <= mem_rd;
      mem_valid <= ex_valid;
      mem_we    <= ex_we;
      mem_rd    <= ex_rd;
      if (bubble) begin
        ex_valid <= 1'b0;
        ex_we    <= 1'b0;
        ex_ld    <= 1'b0;
        ex_rd    <= '0;
      end else begin
        ex_valid <= D_valid;
        ex_we    <= D_we & D_valid;
        ex_ld    <= D_ld & D_valid;
        ex_rd    <= D_rd;
      end
    end
  end

`ifdef HAZ_STALL_CNT_EN
  logic [CNT_W-1:0] cnt_q;

  // Saturating: counts stalled cycles that actually held the front end.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cnt_q <= '0;
    else if (stall && !hold && (cnt_q != '1))
      cnt_q <= cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
  end

  assign stall_cnt = cnt_q;
`else
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - table-driven self-checking bench for hazard_ctrl
module tb_hazard_ctrl;

  localparam int AW = 5;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [AW-1:0] D_ra, D_rb, D_rd;
  logic          D_use_ra, D_use_rb, D_we, D_ld, D_valid, flush, hold;
  logic [1:0]    EX_D_bp, MEM_D_bp, WB_D_bp;
  logic          stall;
  logic [CW-1:0] stall_cnt;

  hazard_ctrl #(.ADDR_SIZE(AW), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .D_ra(D_ra), .D_rb(D_rb), .D_use_ra(D_use_ra), .D_use_rb(D_use_rb),
    .D_rd(D_rd), .D_we(D_we), .D_ld(D_ld), .D_valid(D_valid),
    .flush(flush), .hold(hold),
    .EX_D_bp(EX_D_bp), .MEM_D_bp(MEM_D_bp), .WB_D_bp(WB_D_bp),
    .stall(stall), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] ra, rb;
    logic          use_ra, use_rb;
    logic [AW-1:0] rd;
    logic          we, ld, valid, fl, hd;
    logic [1:0]    ex, mem, wb;
    logic          st;
  } vec_t;

  vec_t vq[$];
  int   tests = 0;
  int   fails = 0;
  int   exp_cnt = 0;

  task automatic add(input int ra, rb, ura, urb, rd, we, ld, v, fl, hd,
                     input logic [1:0] ex, mem, wb, input logic st);
    vec_t r;
    r.ra = AW'(ra); r.rb = AW'(rb); r.use_ra = ura[0]; r.use_rb = urb[0];
    r.rd = AW'(rd); r.we = we[0]; r.ld = ld[0]; r.valid = v[0];
    r.fl = fl[0]; r.hd = hd[0];
    r.ex = ex; r.mem = mem; r.wb = wb; r.st = st;
    vq.push_back(r);
  endtask

  task automatic idle3();
    for (int k = 0; k < 3; k++) add(0,0,0,0,0,0,0,0,0,0, 2'b00,2'b00,2'b00,1'b0);
  endtask

  task automatic chk(input string name, input int idx, input logic [31:0] got, exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s v%0d got %0h exp %0h", name, idx, got, exp);
    end
  endtask

  task automatic drive(input vec_t r);
    D_ra = r.ra; D_rb = r.rb; D_use_ra = r.use_ra; D_use_rb = r.use_rb;
    D_rd = r.rd; D_we = r.we; D_ld = r.ld; D_valid = r.valid;
    flush = r.fl; hold = r.hd;
  endtask

  task automatic chk_zero(input string name, input int idx);
    chk({name, "_ex"},  idx, 32'(EX_D_bp),  32'd0);
    chk({name, "_mem"}, idx, 32'(MEM_D_bp), 32'd0);
    chk({name, "_wb"},  idx, 32'(WB_D_bp),  32'd0);
    chk({name, "_st"},  idx, 32'(stall),    32'd0);
    chk({name, "_cnt"}, idx, 32'(stall_cnt), 32'd0);
  endtask

  initial begin
    //   ra rb ua ub rd we ld v fl hd   ex    mem   wb    st
    // 1: ALU forward from EX
    add(0,0,0,0, 3,1,0,1,0,0, 2'b00,2'b00,2'b00,1'b0);
    add(3,0,1,0, 0,0,0,1,0,0, 2'b10,2'b00,2'b00,1'b0);
    idle3();
    // 2: load-use stalls one cycle, then forwards from MEM
    add(0,0,0,0, 5,1,1,1,0,0, 2'b00,2'b00,2'b00,1'b0);
    add(0,5,0,1, 6,1,0,1,0,0, 2'b01,2'b00,2'b00,1'b1);
    add(0,5,0,1, 6,1,0,1,0,0, 2'b00,2'b01,2'b00,1'b0);
    idle3();
    // 3: three writers of r7, priority EX > MEM > WB
    add(0,0,0,0, 7,1,0,1,0,0, 2'b00,2'b00,2'b00,1'b0);
    add(0,0,0,0, 7,1,0,1,0,0, 2'b00,2'b00,2'b00,1'b0);
    add(0,0,0,0, 7,1,0,1,0,0, 2'b00,2'b00,2'b00,1'b0);
    add(7,7,1,1, 0,0,0,1,0,0, 2'b11,2'b00,2'b00,1'b0);
    add(7,0,1,0, 0,0,0,1,0,0, 2'b00,2'b10,2'b00,1'b0);
    add(7,7,1,1, 0,0,0,1,0,0, 2'b00,2'b00,2'b11,1'b0);
    idle3();
    // 4: r0 writer (a load) never forwards or stalls
    add(0,0,0,0, 0,1,1,1,0,0, 2'b00,2'b00,2'b00,1'b0);
    add(0,0,1,1, 0,0,0,1,0,0, 2'b00,2'b00,2'b00,1'b0);
    idle3();
    // 5: flush beats stall; load moves to MEM behind a bubble
    add(0,0,0,0, 4,1,1,1,0,0, 2'b00,2'b00,2'b00,1'b0);
    add(4,0,1,0, 8,1,0,1,1,0, 2'b10,2'b00,2'b00,1'b0);
    add(4,0,1,0, 0,0,0,1,0,0, 2'b00,2'b10,2'b00,1'b0);
    idle3();
    // 6: load-use under hold: frozen, then one bubble on release
    add(0,0,0,0, 9,1,1,1,0,0, 2'b00,2'b00,2'b00,1'b0);
    add(9,0,1,0, 0,0,0,1,0,1, 2'b10,2'b00,2'b00,1'b1);
    add(9,0,1,0, 0,0,0,1,0,1, 2'b10,2'b00,2'b00,1'b1);
    add(9,0,1,0, 0,0,0,1,0,1, 2'b10,2'b00,2'b00,1'b1);
    add(9,0,1,0, 0,0,0,1,0,0, 2'b10,2'b00,2'b00,1'b1);
    add(9,0,1,0, 0,0,0,1,0,0, 2'b00,2'b10,2'b00,1'b0);
    add(9,0,1,0, 0,0,0,1,0,0, 2'b00,2'b00,2'b10,1'b0);

    rst_n = 1'b0;
    drive('{ra:1, rb:1, use_ra:1, use_rb:1, rd:1, we:1, ld:1, valid:1,
             fl:0, hd:0, ex:0, mem:0, wb:0, st:0});
    repeat (2) @(negedge clk);
    chk_zero("reset", 0);
    rst_n = 1'b1;

    foreach (vq[i]) begin
      @(negedge clk);
      drive(vq[i]);
      #1;
      chk("ex_bp",  i, 32'(EX_D_bp),  32'(vq[i].ex));
      chk("mem_bp", i, 32'(MEM_D_bp), 32'(vq[i].mem));
      chk("wb_bp",  i, 32'(WB_D_bp),  32'(vq[i].wb));
      chk("stall",  i, 32'(stall),    32'(vq[i].st));
      if (vq[i].st && !vq[i].hd) exp_cnt++;
    end

`ifdef HAZ_STALL_CNT_EN
    chk("stall_cnt", 0, 32'(stall_cnt), 32'(exp_cnt));
`else
    chk("stall_cnt", 0, 32'(stall_cnt), 32'd0);
`endif

    // Reset mid-sequence with a load-use pair in flight
    @(negedge clk);
    drive('{ra:0, rb:0, use_ra:0, use_rb:0, rd:11, we:1, ld:1, valid:1,
             fl:0, hd:0, ex:0, mem:0, wb:0, st:0});
    @(negedge clk);
    drive('{ra:11, rb:11, use_ra:1, use_rb:1, rd:0, we:0, ld:0, valid:1,
             fl:0, hd:1, ex:0, mem:0, wb:0, st:0});
    #1;
    chk("pre_rst_st", 0, 32'(stall),   32'd1);
    chk("pre_rst_ex", 0, 32'(EX_D_bp), 32'd3);
    #1;
    rst_n = 1'b0;
    #1;
    chk_zero("async_rst", 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk_zero("post_rst", 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline hazard controller for the decode-stage register file and its bypass muxes.
- Keeps its own shadow record (valid, rd, we, ld) for each of the EX, MEM and WB stages.
- Each cycle it compares the decode instruction's sources against those records. It generates one-hot-priority bypass enables and the load-use stall, and inserts bubbles on stall or flush.

Parameters:
ADDR_SIZE, 5, register index width
CNT_W, 16, stall counter width (used only with the optional feature)

Ports:
clk  input  1  clock, all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
D_ra  input  ADDR_SIZE  decode source A index
D_rb  input  ADDR_SIZE  decode source B index
D_use_ra  input  1  decode instruction reads ra
D_use_rb  input  1  decode instruction reads rb
D_rd  input  ADDR_SIZE  decode destination index
D_we  input  1  decode instruction writes rd
D_ld  input  1  decode instruction is a load
D_valid  input  1  decode slot holds a real instruction
flush  input  1  redirect: kill the decode instruction
hold  input  1  global freeze: no stage advances
EX_D_bp  output  2  {fwd_ra, fwd_rb} from EX
MEM_D_bp  output  2  {fwd_ra, fwd_rb} from MEM
WB_D_bp  output  2  {fwd_ra, fwd_rb} from WB
stall  output  1  load-use stall; hold PC and decode this cycle
stall_cnt  output  CNT_W  total stall cycles (optional feature only)

Behaviour:
- Reset (rst_n low, async): all stage records cleared (valid=0, we=0, ld=0, rd=0).
  - All bypass outputs are 0 and stall is 0, because they are derived from the cleared records.
  - stall_cnt = 0.
- Stage record S "hits" operand X when all of the following hold:
  - S.valid, S.we, and S.rd == D_X;
  - D_X != 0;
  - D_use_X and D_valid.
- Bypass priority per operand is EX > MEM > WB. At most one of EX/MEM/WB bits is set per operand; lower-priority bits are suppressed when a higher stage hits.
- Bypass outputs are combinational from the current records and decode inputs, with zero latency.
- Load-use stall:
  - stall = EX hits ra or rb, AND EX.ld, AND !flush.
  - While stall=1 the EX bypass bit for that operand is still driven, but the result is ignored because a bubble is inserted.
- Sequential update on posedge clk with rst_n high:
  - hold=1: all records keep their value and stall_cnt does not change.
  - hold=0, flush=1 or stall=1: EX <= bubble (valid=0, we=0, ld=0); MEM <= EX; WB <= MEM.
  - hold=0 otherwise: EX <= {D_valid, D_rd, D_we & D_valid, D_ld & D_valid}; MEM <= EX; WB <= MEM.
- A load in MEM does not stall; it forwards through MEM_D_bp, because MEM data carries load data.
- A stall lasts exactly one cycle per load-use pair. The next cycle the load sits in MEM and MEM_D_bp is set.
- A record with rd=0 and we=1 never forwards and never stalls.
- flush and stall in the same cycle: flush wins, stall=0, one bubble is inserted.
- hold and stall in the same cycle: stall output stays asserted, no state changes.
- Reset asserted mid-operation: all in-flight records are discarded immediately and outputs go to 0 asynchronously.

Optional Feature:
- Macro: HAZ_STALL_CNT_EN.
- Defined:
  - stall_cnt increments by 1 on each posedge where stall=1 and hold=0.
  - It saturates at all-ones and does not wrap.
  - It is cleared only by reset.
- Undefined: stall_cnt is tied to 0 and the counter register is not built.

Test Plan:
1. Reset, then decode add rd=3, next cycle decode D_ra=3 (use_ra=1) -> EX_D_bp=2'b10, MEM_D_bp=0, WB_D_bp=0, stall=0.
2. Load rd=5, then D_rb=5 immediately -> stall=1 for exactly one cycle; next cycle MEM_D_bp=2'b01, EX_D_bp=0, stall=0; stall_cnt=1 with HAZ_STALL_CNT_EN.
3. Writes to rd=7 from EX, MEM and WB simultaneously (three back-to-back writers), decode D_ra=D_rb=7 -> EX_D_bp=2'b11, MEM_D_bp=0, WB_D_bp=0.
4. Writer rd=0 in EX, decode D_ra=0 -> all bypass outputs 0, stall=0, even when the writer is a load.
5. Load rd=4 in EX, decode D_ra=4 with flush=1 -> stall=0; after the edge EX.valid=0 and MEM holds the load.
6. Load-use with hold=1 for 3 cycles -> stall stays 1 and records are frozen, stall_cnt unchanged; on release one bubble is inserted; drop rst_n mid-sequence -> all outputs 0 immediately.
